// File: rtl/request_latch8.sv
// request_latch8: sticky request capture feeding the 8-to-3 priority encoder
// Ports: clk, rst (sync, active-high); req_in[7:0] raw request levels;
//   mask[7:0] hides bits from pend_out only; ack/ack_code[2:0] clear one pending bit;
//   pend_out[7:0] = pending & ~mask; any_pend = |pend_out;
//   overflow[7:0] sticky re-edge-while-pending; ack_err one-cycle bad-ack pulse.
// Define REQ_LATCH_SYNC_EN to insert a two-flop synchroniser on req_in.
module request_latch8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic [2:0] ack_code,
    output logic [7:0] pend_out,
    output logic       any_pend,
    output logic [7:0] overflow,
    output logic       ack_err
);
    logic [7:0] s_cur, s_prev, pending, rise, clr;
`ifdef REQ_LATCH_SYNC_EN
    logic [7:0] sync1, sync2;
    always_ff @(posedge clk)
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= req_in;
            sync2 <= sync1;
        end
    assign s_cur = sync2;
`else
    assign s_cur = req_in;
`endif
    assign rise     = s_cur & ~s_prev;
    assign clr      = ack ? 8'd1 << ack_code : 8'd0;
    assign pend_out = pending & ~mask;
    assign any_pend = |pend_out;
    // a new edge always wins over a clear so no request is lost
    always_ff @(posedge clk)
        if (rst) begin
            s_prev   <= '0;
            pending  <= '0;
            overflow <= '0;
            ack_err  <= 1'b0;
        end else begin
            s_prev   <= s_cur;
            pending  <= rise | (pending & ~clr);
            overflow <= (overflow & ~(clr & ~rise)) | (rise & pending & ~clr);
            ack_err  <= ack & ~pending[ack_code];
        end
endmodule

// File: tb/tb_request_latch8.sv
// tb_request_latch8: directed self-checking bench for request_latch8
module tb_request_latch8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = '0;
    logic [7:0] mask = '0;
    logic       ack = 1'b0;
    logic [2:0] ack_code = '0;
    logic [7:0] pend_out, overflow;
    logic       any_pend, ack_err;
    int total = 0;
    int bad = 0;
`ifdef REQ_LATCH_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif
    request_latch8 dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_code(ack_code), .pend_out(pend_out), .any_pend(any_pend),
        .overflow(overflow), .ack_err(ack_err)
    );
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b1; req_in = '0; mask = '0; ack = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL rst_pend got %h want 00", pend_out); end
        total++; if (any_pend !== 1'b0) begin bad++; $display("FAIL rst_any got %b want 0", any_pend); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL rst_ovf got %h want 00", overflow); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", ack_err); end
    endtask
    task automatic test_capture;
        req_in = 8'h21;
        step(L - 1);
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL cap_early got %h want 00", pend_out); end
        step(1);
        req_in = 8'h00;
        total++; if (pend_out !== 8'h21) begin bad++; $display("FAIL cap_pend got %h want 21", pend_out); end
        total++; if (any_pend !== 1'b1) begin bad++; $display("FAIL cap_any got %b want 1", any_pend); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL cap_ovf got %h want 00", overflow); end
        step(3);
        total++; if (pend_out !== 8'h21) begin bad++; $display("FAIL cap_hold got %h want 21", pend_out); end
    endtask
    task automatic test_back_to_back;
        ack = 1'b1; ack_code = 3'd5;
        step(1);
        total++; if (pend_out !== 8'h01) begin bad++; $display("FAIL b2b_first got %h want 01", pend_out); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL b2b_err1 got %b want 0", ack_err); end
        ack_code = 3'd0;
        step(1);
        ack = 1'b0;
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL b2b_second got %h want 00", pend_out); end
        total++; if (any_pend !== 1'b0) begin bad++; $display("FAIL b2b_any got %b want 0", any_pend); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL b2b_err2 got %b want 0", ack_err); end
    endtask
    task automatic test_overflow;
        req_in = 8'h08;
        step(L);
        req_in = 8'h00;
        total++; if (pend_out !== 8'h08) begin bad++; $display("FAIL ovf_first got %h want 08", pend_out); end
        step(3);
        req_in = 8'h08;
        step(L);
        req_in = 8'h00;
        total++; if (overflow !== 8'h08) begin bad++; $display("FAIL ovf_set got %h want 08", overflow); end
        total++; if (pend_out !== 8'h08) begin bad++; $display("FAIL ovf_pend got %h want 08", pend_out); end
        step(3);
        ack = 1'b1; ack_code = 3'd3;
        step(1);
        ack = 1'b0;
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL ovf_ack_pend got %h want 00", pend_out); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL ovf_ack_clr got %h want 00", overflow); end
    endtask
    task automatic test_set_wins;
        req_in = 8'h04;
        step(L);
        req_in = 8'h00;
        step(3);
        req_in = 8'h04;
        step(L);
        req_in = 8'h00;
        step(3);
        total++; if (overflow !== 8'h04) begin bad++; $display("FAIL sw_pre_ovf got %h want 04", overflow); end
        req_in = 8'h04;
        step(L - 1);
        ack = 1'b1; ack_code = 3'd2;
        step(1);
        ack = 1'b0;
        req_in = 8'h00;
        total++; if (pend_out !== 8'h04) begin bad++; $display("FAIL sw_pend got %h want 04", pend_out); end
        total++; if (overflow !== 8'h04) begin bad++; $display("FAIL sw_ovf got %h want 04", overflow); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL sw_err got %b want 0", ack_err); end
        step(3);
        ack = 1'b1; ack_code = 3'd2;
        step(1);
        ack = 1'b0;
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL sw_clr_pend got %h want 00", pend_out); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL sw_clr_ovf got %h want 00", overflow); end
    endtask
    task automatic test_mask;
        mask = 8'hFF; req_in = 8'h80;
        step(L);
        req_in = 8'h00;
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL msk_pend got %h want 00", pend_out); end
        total++; if (any_pend !== 1'b0) begin bad++; $display("FAIL msk_any got %b want 0", any_pend); end
        mask = 8'h00;
        #1;
        total++; if (pend_out !== 8'h80) begin bad++; $display("FAIL msk_unmask got %h want 80", pend_out); end
        total++; if (any_pend !== 1'b1) begin bad++; $display("FAIL msk_unmask_any got %b want 1", any_pend); end
        ack = 1'b1; ack_code = 3'd4;
        step(1);
        ack = 1'b0;
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL msk_err_pulse got %b want 1", ack_err); end
        total++; if (pend_out !== 8'h80) begin bad++; $display("FAIL msk_err_pend got %h want 80", pend_out); end
        step(1);
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL msk_err_end got %b want 0", ack_err); end
        ack = 1'b1; ack_code = 3'd7;
        step(1);
        ack = 1'b0;
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL msk_ack7 got %h want 00", pend_out); end
        step(3);
    endtask
    task automatic test_reset_mid;
        req_in = 8'hFF;
        step(L);
        total++; if (pend_out !== 8'hFF) begin bad++; $display("FAIL rm_full got %h want ff", pend_out); end
        req_in = 8'h01; rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL rm_pend got %h want 00", pend_out); end
        total++; if (any_pend !== 1'b0) begin bad++; $display("FAIL rm_any got %b want 0", any_pend); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL rm_ovf got %h want 00", overflow); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL rm_err got %b want 0", ack_err); end
        step(L - 1);
        total++; if (pend_out !== 8'h00) begin bad++; $display("FAIL rm_early got %h want 00", pend_out); end
        step(1);
        total++; if (pend_out !== 8'h01) begin bad++; $display("FAIL rm_relatch got %h want 01", pend_out); end
        step(4);
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL rm_level_hold got %h want 00", overflow); end
    endtask
    initial begin
        test_reset;
        test_capture;
        test_back_to_back;
        test_overflow;
        test_set_wins;
        test_mask;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/request_latch8.md
# request_latch8

Upstream request-capture stage for the 8-to-3 priority encoder. Synchronises eight asynchronous request lines and detects their rising edges. Holds each request in a sticky pending bit until it is acknowledged by code, and presents the masked pending vector as the encoder's `in`. The encoder's `code` is routed back as `ack_code`, closing the service loop.

## Interface
Parameters: none (width fixed at 8 to match the encoder).
- `clk`  input  1  single system clock, rising edge
- `rst`  input  1  synchronous, active-high reset
- `req_in`  input  8  raw request lines, asynchronous to `clk`, level
- `mask`  input  8  1 = suppress bit from `pend_out` (still latched)
- `ack`  input  1  one-cycle acknowledge strobe from the servicing logic
- `ack_code`  input  3  index of the request being acknowledged (encoder `code`)
- `pend_out`  output  8  `pending & ~mask`, drives encoder `in`
- `any_pend`  output  1  `|pend_out`
- `overflow`  output  8  sticky: a new edge arrived while that bit was already pending
- `ack_err`  output  1  registered one-cycle pulse: `ack` named a bit that was not pending

## Operation
- Input path: `s_cur` is the synchronised request (see Configuration). `s_prev` is `s_cur` registered. `edge = s_cur & ~s_prev`.
- Pending set: each cycle, `pending[i] <= edge[i] | (pending[i] & ~clr[i])`.
  - `clr[i] = ack & (ack_code == i)`.
  - Set wins over clear on the same bit in the same cycle, so no edge is lost.
- Overflow: `overflow[i] <= 1` when `edge[i] & pending[i] & ~clr[i]`.
  - Cleared only by `clr[i]` in a cycle where `edge[i]` is 0.
  - Otherwise sticky.
- Ack error: `ack_err <= ack & ~pending[ack_code]`. Such an ack has no other effect.
- Mask affects only `pend_out` and `any_pend`. A masked bit still sets, overflows and can be acked. Unmasking exposes it immediately (combinational).
- Level-held requests produce exactly one pending set per rising edge. A line held high never re-triggers.
- `ack_code` is evaluated only when `ack` = 1.
- Reset: `pending`, `overflow`, `ack_err`, `s_prev` and both synchroniser flops go to 0. `pend_out` = 0 and `any_pend` = 0.
- A line already high when reset is released is seen as a rising edge once it propagates, and is latched.
- Reset mid-operation discards all pending and overflow state in the same cycle.

## Timing
- All state updates on the rising `clk` edge. `pend_out` and `any_pend` are combinational from `pending` and `mask`.
- With `REQ_LATCH_SYNC_EN`:
  - `req_in` rising, sampled at edge k, gives `pending` set after edge k+2.
  - This is 3 edges from first sample to visible `pend_out`.
- Without the macro: `req_in` high before edge k gives `pending` set after edge k.
- Ack latency:
  - `ack` sampled at edge k clears the bit after edge k; `pend_out` drops in cycle k+1.
  - `ack_err` is high for exactly cycle k+1.
- Back-to-back acks on consecutive cycles are legal. Each is evaluated against the `pending` value of its own cycle.
- Minimum `req_in` low time for a second edge to be detected: 2 clocks with the synchroniser, 1 clock without.

## Configuration
- `REQ_LATCH_SYNC_EN` defined:
  - Two-flop synchroniser per bit (`sync1 <= req_in`, `sync2 <= sync1`, `s_cur = sync2`).
  - Required when `req_in` is asynchronous.
- Not defined:
  - `s_cur = req_in` directly, with no extra latency.
  - Only for requests already synchronous to `clk`.
- Overflow, ack and mask behaviour are identical in both builds. Only the latency differs.

## Test plan
- Reset release with `req_in`=8'h00, then pulse `req_in`=8'h21 → `pend_out`=8'h21 after 3 edges (sync build) / 1 edge (non-sync build); `any_pend`=1; `overflow`=0.
- With `pending`=8'h21: `ack`=1, `ack_code`=5 → next cycle `pend_out`=8'h01. Then `ack_code`=0 → `pend_out`=8'h00, `any_pend`=0, `ack_err` never asserted.
- Bit 3 pending; raise a second edge on bit 3 with no ack → `overflow`=8'h08, `pending[3]`=1. Ack bit 3 → `pending[3]`=0 and `overflow`=8'h00 one cycle later.
- Edge on bit 2 arriving in the same cycle as `ack` with `ack_code`=2 while `pending[2]`=1 → `pending[2]` stays 1 and `overflow[2]`=1.
- `mask`=8'hFF, edge on bit 7 → `pend_out`=8'h00 and `any_pend`=0. `mask`←8'h00 → `pend_out`=8'h80 in the same cycle. `ack` with `ack_code`=4 (not pending) → `ack_err` pulses one cycle, `pending` unchanged.
- `pending`=8'hFF, assert `rst` for one cycle with `req_in` held at 8'h01 → all outputs 0 after the reset edge. Bit 0 re-latches after the synchroniser latency, because `s_prev` reset to 0.
